alu_control_seq: RTL and testbench

- Parametrised next-generation ALU control unit for the MIPS datapath; sits in EX between the main control unit and the ALU.
- Decodes {alu_op_i, alu_function_i} into an ALU operation code.
- Adds an extended op table and an illegal-op flag.
- Adds a sequencer for multi-cycle MULT/MULTU/DIV/DIVU that pulses start to the HI/LO multiply-divide unit, stalls the pipeline for a fixed latency, and writes HI/LO.

---
 rtl/alu_ctrl_pkg.sv | 60 ++++++
 rtl/alu_control_seq_if.sv | 30 +++
 rtl/alu_control_seq_decode.sv | 59 +++++
 rtl/alu_control_seq.sv | 125 ++++++++++++
 tb/tb_alu_control_seq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control unit and its MD sequencer.
// Holds op classes, funct codes, operation codes, MD op encodings, FSM states.
package alu_ctrl_pkg;

    localparam logic [2:0] AOP_LWSW  = 3'b000;
    localparam logic [2:0] AOP_BR    = 3'b001;
    localparam logic [2:0] AOP_SLTI  = 3'b010;
    localparam logic [2:0] AOP_ANDI  = 3'b011;
    localparam logic [2:0] AOP_ADDI  = 3'b100;
    localparam logic [2:0] AOP_ORI   = 3'b101;
    localparam logic [2:0] AOP_LUI   = 3'b110;
    localparam logic [2:0] AOP_RTYPE = 3'b111;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;

    localparam logic [3:0] OP_SLL     = 4'b0000;
    localparam logic [3:0] OP_SRL     = 4'b0001;
    localparam logic [3:0] OP_OR      = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_LUI     = 4'b0101;
    localparam logic [3:0] OP_AND     = 4'b0110;
    localparam logic [3:0] OP_NOR     = 4'b0111;
    localparam logic [3:0] OP_SLT     = 4'b1000;
    localparam logic [3:0] OP_NOP     = 4'b1001;
    localparam logic [3:0] OP_XOR     = 4'b1010;
    localparam logic [3:0] OP_PASS_HI = 4'b1100;
    localparam logic [3:0] OP_PASS_LO = 4'b1101;

    typedef logic [1:0] md_op_t;
    localparam md_op_t MD_MULT  = 2'b00;
    localparam md_op_t MD_MULTU = 2'b01;
    localparam md_op_t MD_DIV   = 2'b10;
    localparam md_op_t MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// EX-stage bundle between main control and the ALU control unit.
// slave: the ALU control unit; master: the pipeline/control side.
interface alu_ctrl_if
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_OP_WIDTH    = 3,
    parameter int OPERATION_WIDTH = 4
);
    logic                       valid_i;
    logic [ALU_OP_WIDTH-1:0]    alu_op_i;
    logic [5:0]                 alu_function_i;
    logic [OPERATION_WIDTH-1:0] alu_operation_o;
    logic                       illegal_o;
    logic                       md_start_o;
    md_op_t                     md_op_o;
    logic                       stall_o;
    logic                       hilo_we_o;

    modport master (
        output valid_i, alu_op_i, alu_function_i,
        input  alu_operation_o, illegal_o, md_start_o,
        input  md_op_o, stall_o, hilo_we_o
    );

    modport slave (
        input  valid_i, alu_op_i, alu_function_i,
        output alu_operation_o, illegal_o, md_start_o,
        output md_op_o, stall_o, hilo_we_o
    );
endinterface

// File: rtl/alu_control_seq_decode.sv
// Combinational selector decode: {alu_op, funct} -> operation/illegal/MD info.
// Ports: i_valid, i_alu_op, i_funct in; o_operation, o_illegal, o_is_md, o_md_op out.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_OP_WIDTH    = 3,
    parameter int OPERATION_WIDTH = 4
) (
    input  logic                       i_valid,
    input  logic [ALU_OP_WIDTH-1:0]    i_alu_op,
    input  logic [5:0]                 i_funct,
    output logic [OPERATION_WIDTH-1:0] o_operation,
    output logic                       o_illegal,
    output logic                       o_is_md,
    output md_op_t                     o_md_op
);
    logic [3:0] w_op;
    logic       w_unmapped;
    logic       w_is_md;

    always_comb begin
        w_op       = OP_NOP;
        w_unmapped = 1'b0;
        w_is_md    = 1'b0;
        case (i_alu_op)
            ALU_OP_WIDTH'(AOP_LWSW):  w_op = OP_ADD;
            ALU_OP_WIDTH'(AOP_BR):    w_op = OP_SUB;
            ALU_OP_WIDTH'(AOP_SLTI):  w_op = OP_SLT;
            ALU_OP_WIDTH'(AOP_ANDI):  w_op = OP_AND;
            ALU_OP_WIDTH'(AOP_ADDI):  w_op = OP_ADD;
            ALU_OP_WIDTH'(AOP_ORI):   w_op = OP_OR;
            ALU_OP_WIDTH'(AOP_LUI):   w_op = OP_LUI;
            ALU_OP_WIDTH'(AOP_RTYPE): begin
                case (i_funct)
                    F_ADD:  w_op = OP_ADD;
                    F_SUB:  w_op = OP_SUB;
                    F_AND:  w_op = OP_AND;
                    F_OR:   w_op = OP_OR;
                    F_XOR:  w_op = OP_XOR;
                    F_NOR:  w_op = OP_NOR;
                    F_SLT:  w_op = OP_SLT;
                    F_SLL:  w_op = OP_SLL;
                    F_SRL:  w_op = OP_SRL;
                    F_MFHI: w_op = OP_PASS_HI;
                    F_MFLO: w_op = OP_PASS_LO;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: w_is_md = 1'b1;
                    default: w_unmapped = 1'b1;
                endcase
            end
            default: w_unmapped = 1'b1;
        endcase
    end

    // funct[1:0] of 0110xx already matches the MD op encoding
    assign o_md_op     = i_funct[1:0];
    assign o_is_md     = w_is_md;
    assign o_operation = OPERATION_WIDTH'(w_op);
    assign o_illegal   = w_unmapped & i_valid;
endmodule

// File: rtl/alu_control_seq.sv
// EX-stage ALU control with multi-cycle MULT/DIV sequencer (IDLE/BUSY/DONE).
// Ports: clk, reset (sync, active-high), bus (alu_ctrl_if.slave).
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_OP_WIDTH    = 3,
    parameter int OPERATION_WIDTH = 4,
    parameter int MUL_LATENCY     = 4,
    parameter int DIV_LATENCY     = 32,
    parameter int REG_OUT         = 0
) (
    input  logic       clk,
    input  logic       reset,
    alu_ctrl_if.slave  bus
);
    localparam int MAXLAT = max_int(MUL_LATENCY, DIV_LATENCY);
    localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);

    logic [OPERATION_WIDTH-1:0] w_op;
    logic                       w_ill;
    logic                       w_is_md;
    md_op_t                     w_dec_md_op;

    alu_op_decode #(
        .ALU_OP_WIDTH    (ALU_OP_WIDTH),
        .OPERATION_WIDTH (OPERATION_WIDTH)
    ) u_dec (
        .i_valid     (bus.valid_i),
        .i_alu_op    (bus.alu_op_i),
        .i_funct     (bus.alu_function_i),
        .o_operation (w_op),
        .o_illegal   (w_ill),
        .o_is_md     (w_is_md),
        .o_md_op     (w_dec_md_op)
    );

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_load;
    md_op_t          r_md_op;
    md_op_t          w_md_op_nxt;
    md_op_t          w_md_op_out;
    logic            w_start;
    logic            w_stall;
    logic            w_hilo_we;

    assign w_load = w_dec_md_op[1] ? DIV_LOAD : MUL_LOAD;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_op_nxt = r_md_op;
        w_md_op_out = r_md_op;
        w_start     = 1'b0;
        w_stall     = 1'b0;
        w_hilo_we   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.valid_i && w_is_md) begin
                    w_start     = 1'b1;
                    w_stall     = 1'b1;
                    w_md_op_nxt = w_dec_md_op;
                    // MD unit needs the op in the start cycle itself
                    w_md_op_out = w_dec_md_op;
                    w_cnt_nxt   = w_load;
                    w_state_nxt = (w_load == '0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt - 1'b1;
                // counter hits 0 on the last stall cycle, so DONE lands
                // exactly LATENCY cycles after the accept
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_hilo_we   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_md_op <= MD_MULT;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_md_op <= w_md_op_nxt;
        end
    end

    assign bus.md_start_o = w_start;
    assign bus.md_op_o    = w_md_op_out;
    assign bus.stall_o    = w_stall;
    assign bus.hilo_we_o  = w_hilo_we;

    if (REG_OUT != 0) begin : g_reg
        logic [OPERATION_WIDTH-1:0] r_op;
        logic                       r_ill;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_op  <= OPERATION_WIDTH'(OP_NOP);
                r_ill <= 1'b0;
            end else begin
                r_op  <= w_op;
                r_ill <= w_ill;
            end
        end
        assign bus.alu_operation_o = r_op;
        assign bus.illegal_o       = r_ill;
    end else begin : g_comb
        assign bus.alu_operation_o = w_op;
        assign bus.illegal_o       = w_ill;
    end
endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench: two DUT configs, schedule-based model, directed + random.
module tb_alu_control_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v = 1'b0;
    logic [2:0] aop = 3'd0;
    logic [5:0] fn = 6'd0;

    always #5 clk = ~clk;

    alu_ctrl_if #(.ALU_OP_WIDTH(3), .OPERATION_WIDTH(4)) b0 ();
    alu_ctrl_if #(.ALU_OP_WIDTH(3), .OPERATION_WIDTH(4)) b1 ();

    assign b0.valid_i        = v;
    assign b0.alu_op_i       = aop;
    assign b0.alu_function_i = fn;
    assign b1.valid_i        = v;
    assign b1.alu_op_i       = aop;
    assign b1.alu_function_i = fn;

    alu_control_seq #(
        .ALU_OP_WIDTH(3), .OPERATION_WIDTH(4),
        .MUL_LATENCY(4), .DIV_LATENCY(32), .REG_OUT(0)
    ) u0 (.clk(clk), .reset(reset), .bus(b0));

    alu_control_seq #(
        .ALU_OP_WIDTH(3), .OPERATION_WIDTH(4),
        .MUL_LATENCY(1), .DIV_LATENCY(3), .REG_OUT(1)
    ) u1 (.clk(clk), .reset(reset), .bus(b1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the op tables
    function automatic void ref_dec(input logic [2:0] a, input logic [5:0] f,
                                    output int op, output bit unm,
                                    output bit md);
        int cls [8] = '{3, 4, 8, 6, 3, 2, 5, -1};
        unm = 0;
        md  = 0;
        op  = cls[a];
        if (a == 3'd7) begin
            md = (f[5:2] == 4'b0110);
            if (md) op = 9;
            else if (f == 6'h20) op = 3;
            else if (f == 6'h22) op = 4;
            else if (f == 6'h24) op = 6;
            else if (f == 6'h25) op = 2;
            else if (f == 6'h26) op = 10;
            else if (f == 6'h27) op = 7;
            else if (f == 6'h2a) op = 8;
            else if (f == 6'h00) op = 0;
            else if (f == 6'h02) op = 1;
            else if (f == 6'h10) op = 12;
            else if (f == 6'h12) op = 13;
            else begin op = 9; unm = 1; end
        end
    endfunction

    // Model: an accepted MD op at cycle t stalls cycles t..t+L-1 and
    // writes HI/LO at t+L; the unit is free again from t+L+1.
    int  LM [2] = '{4, 1};
    int  LD [2] = '{32, 3};
    bit  busy [2];
    int  acc [2];
    int  lat [2];
    int  held [2];
    int  prev_op;
    bit  prev_ill;
    bit  armed = 0;
    int  n = 0;

    always @(negedge clk) begin : cmp
        int op;
        bit unm, md;
        int e_sta, e_st, e_hw, e_mo, k;
        logic a_sta, a_st, a_hw;
        logic [1:0] a_mo;
        ref_dec(aop, fn, op, unm, md);
        if (armed) begin
            chk("op0", b0.alu_operation_o, op);
            chk("ill0", b0.illegal_o, unm & v);
            chk("op1_reg", b1.alu_operation_o, prev_op);
            chk("ill1_reg", b1.illegal_o, prev_ill);
        end
        if (reset) begin
            busy     = '{0, 0};
            held     = '{0, 0};
            prev_op  = 9;
            prev_ill = 0;
            armed    = 1;
        end else if (armed) begin
            for (int d = 0; d < 2; d++) begin
                e_sta = 0; e_st = 0; e_hw = 0;
                if (busy[d]) begin
                    k = n - acc[d];
                    if (k < lat[d]) e_st = 1;
                    else begin e_hw = 1; busy[d] = 0; end
                end else if (v && md) begin
                    e_sta   = 1;
                    e_st    = 1;
                    held[d] = fn[1:0];
                    busy[d] = 1;
                    acc[d]  = n;
                    lat[d]  = fn[1] ? LD[d] : LM[d];
                end
                e_mo = held[d];
                a_sta = d == 0 ? b0.md_start_o : b1.md_start_o;
                a_st  = d == 0 ? b0.stall_o : b1.stall_o;
                a_hw  = d == 0 ? b0.hilo_we_o : b1.hilo_we_o;
                a_mo  = d == 0 ? b0.md_op_o : b1.md_op_o;
                chk($sformatf("start%0d", d), a_sta, e_sta);
                chk($sformatf("stall%0d", d), a_st, e_st);
                chk($sformatf("hilo_we%0d", d), a_hw, e_hw);
                chk($sformatf("md_op%0d", d), a_mo, e_mo);
            end
            prev_op  = op;
            prev_ill = unm & v;
        end
        n++;
    end

    task automatic step(input bit vv, input logic [2:0] a,
                        input logic [5:0] f);
        @(posedge clk);
        #1;
        v = vv; aop = a; fn = f;
        @(negedge clk);
    endtask

    // Issue an MD op on DUT0 and measure its stall length literally
    task automatic md_run(input logic [5:0] f, input int exp_lat,
                          input int exp_op, input bit chk1);
        int cnt;
        bit hw;
        step(1'b1, 3'd7, f);
        chk("md_start_acc", b0.md_start_o, 1);
        chk("md_op_acc", b0.md_op_o, exp_op);
        chk("md_stall_acc", b0.stall_o, 1);
        if (chk1) chk("lat1_start", b1.md_start_o, 1);
        cnt = 1;
        hw  = 0;
        for (int i = 0; i < 100 && !hw; i++) begin
            @(negedge clk);
            if (chk1 && i == 0) begin
                chk("lat1_we", b1.hilo_we_o, 1);
                chk("lat1_stall", b1.stall_o, 0);
            end
            if (b0.hilo_we_o) begin
                hw = 1;
                chk("md_stall_at_we", b0.stall_o, 0);
                chk("md_op_hold", b0.md_op_o, exp_op);
            end else if (b0.stall_o) begin
                cnt++;
            end
        end
        chk("md_we_seen", hw, 1);
        chk("md_stall_len", cnt, exp_lat);
    endtask

    initial begin : drv
        bit any_we;
        logic [5:0] legal [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                                   6'h27, 6'h2a, 6'h00, 6'h02, 6'h10, 6'h12};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", b0.stall_o, 0);
        chk("rst_md_op", b0.md_op_o, 0);
        chk("rst_op1", b1.alu_operation_o, 9);
        chk("rst_ill1", b1.illegal_o, 0);

        step(1'b1, 3'd7, 6'b100000);
        chk("dir_add", b0.alu_operation_o, 4'b0011);
        chk("dir_add_ill", b0.illegal_o, 0);
        chk("dir_add_stall", b0.stall_o, 0);
        step(1'b1, 3'd7, 6'b100111);
        chk("dir_nor", b0.alu_operation_o, 4'b0111);
        step(1'b1, 3'd7, 6'b101010);
        chk("dir_slt", b0.alu_operation_o, 4'b1000);
        step(1'b1, 3'd4, 6'($urandom));
        chk("dir_addi", b0.alu_operation_o, 4'b0011);
        step(1'b1, 3'd5, 6'($urandom));
        chk("dir_ori", b0.alu_operation_o, 4'b0010);
        step(1'b1, 3'd6, 6'($urandom));
        chk("dir_lui", b0.alu_operation_o, 4'b0101);
        step(1'b1, 3'd3, 6'($urandom));
        chk("dir_andi", b0.alu_operation_o, 4'b0110);
        step(1'b1, 3'd7, 6'b111111);
        chk("dir_unm_op", b0.alu_operation_o, 4'b1001);
        chk("dir_unm_ill", b0.illegal_o, 1);
        step(1'b0, 3'd7, 6'b111111);
        chk("dir_unm_ill_v0", b0.illegal_o, 0);
        chk("dir_unm_op_v0", b0.alu_operation_o, 4'b1001);

        md_run(6'b011000, 4, 0, 1'b1);
        step(1'b0, 3'd0, 6'd0);
        chk("mul_no_restart", b0.md_start_o, 0);
        chk("mul_idle_stall", b0.stall_o, 0);

        md_run(6'b011011, 32, 3, 1'b0);
        step(1'b1, 3'd7, 6'b010010);
        chk("mflo_op", b0.alu_operation_o, 4'b1101);
        chk("mflo_stall", b0.stall_o, 0);

        step(1'b1, 3'd7, 6'b011010);
        repeat (10) @(negedge clk);
        chk("div_busy10", b0.stall_o, 1);
        @(posedge clk);
        #1 reset = 1'b1; v = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_stall", b0.stall_o, 0);
        chk("abort_we", b0.hilo_we_o, 0);
        any_we = 0;
        repeat (40) begin
            @(negedge clk);
            any_we |= b0.hilo_we_o;
        end
        chk("abort_no_we", any_we, 0);
        md_run(6'b011000, 4, 0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            int r;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) == 0);
            v     = ($urandom_range(0, 4) != 0);
            aop   = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom);
            r     = $urandom_range(0, 9);
            if (r < 3) fn = {4'b0110, 2'($urandom)};
            else if (r < 8) fn = legal[$urandom_range(0, 10)];
            else fn = 6'($urandom);
        end
        @(posedge clk);
        #1 reset = 1'b0; v = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
